// File: rtl/display_scan_controller_pkg.sv
// Shared types and constants for the multiplexed 7-segment display controller.
package display_scan_controller_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // Code the external decoder renders as a dark digit.
    localparam logic [3:0] BLANK_CODE = 4'hF;

endpackage

// File: rtl/display_scan_controller_if.sv
// Load handshake and display-pin bundle between the value source and the scan controller.
interface display_scan_controller_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 14
);
    logic                  load;
    logic [DATA_W-1:0]     value;
    logic                  busy;
    logic                  done;
    logic                  ovf;
    logic [3:0]            digit_code;
    logic [NUM_DIGITS-1:0] anode_n;

    modport master (
        output load, value,
        input  busy, done, ovf, digit_code, anode_n
    );

    modport slave (
        input  load, value,
        output busy, done, ovf, digit_code, anode_n
    );
endinterface

// File: rtl/display_scan_controller_bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter: one bit per cycle, DATA_W cycles per value.
module bin2bcd_seq #(
    parameter int DATA_W  = 14,
    parameter int NUM_NIB = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [DATA_W-1:0]     bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [NUM_NIB*4-1:0]  bcd_o
);
    localparam int BCD_W = NUM_NIB * 4;
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_NIB; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        if (cnt_q == '0) begin
            if (start_i) begin
                bin_d = bin_i;
                bcd_d = '0;
                cnt_d = CNT_W'(DATA_W);
            end
        end else begin
            {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
            cnt_d          = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);
    // High during the final shift, so bcd_o is complete on the following cycle.
    assign done_o = (cnt_q == CNT_W'(1));
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/display_scan_controller.sv
// Captures a binary value, converts it to BCD, and scans it onto a multiplexed
// common-anode display through one shared external digit decoder.
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int DATA_W      = 14,
    parameter int REFRESH_DIV = 100000,
    parameter int LZ_BLANK    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    display_scan_controller_if.slave bus
);
    localparam int NUM_NIB = NUM_DIGITS + 1;
    localparam int RW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_e state_q, state_d;
    logic   busy, start, commit;

    logic                   eng_busy, eng_done;
    logic [NUM_NIB*4-1:0]   eng_bcd;

    logic [NUM_DIGITS-1:0][3:0] digits_q, digits_d;
    logic                       ovf_q, ovf_d;
    logic                       done_q;
    logic [NUM_DIGITS-1:0]      upper_zero;

    logic [RW-1:0]         refresh_q, refresh_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [3:0]            code_q;
    logic [NUM_DIGITS-1:0] anode_q;

    bin2bcd_seq #(
        .DATA_W  (DATA_W),
        .NUM_NIB (NUM_NIB)
    ) u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .bin_i   (bus.value),
        .busy_o  (eng_busy),
        .done_o  (eng_done),
        .bcd_o   (eng_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.load) state_d = CONV;
            CONV:    if (eng_done) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        start  = (state_q == IDLE) && bus.load && !eng_busy;
        commit = (state_q == COMMIT);
    end

    // Anything left in the spare top nibble means the value has too many digits.
    assign ovf_d = (eng_bcd[NUM_NIB*4-1 -: 4] != 4'd0);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign upper_zero[gi] = (eng_bcd[NUM_DIGITS*4-1 : gi*4] == '0);
            if (gi == 0) begin : g_lsd
                assign digits_d[gi] = ovf_d ? BLANK_CODE : eng_bcd[3:0];
            end else begin : g_upper
                assign digits_d[gi] = (ovf_d || (LZ_BLANK != 0 && upper_zero[gi])) ?
                                      BLANK_CODE : eng_bcd[gi*4 +: 4];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q <= {NUM_DIGITS{BLANK_CODE}};
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= commit;
            if (commit) begin
                digits_q <= digits_d;
                ovf_q    <= ovf_d;
            end
        end
    end

    always_comb begin
        refresh_d = refresh_q + RW'(1);
        idx_d     = idx_q;
        if (refresh_q == RW'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            idx_d     = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    // Code and anode are registered together from the same index to avoid ghosting.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_q <= '0;
            idx_q     <= '0;
            code_q    <= BLANK_CODE;
            anode_q   <= ~NUM_DIGITS'(1);
        end else begin
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            code_q    <= digits_q[idx_q];
            anode_q   <= ~(NUM_DIGITS'(1) << idx_q);
        end
    end

    assign bus.busy       = busy;
    assign bus.done       = done_q;
    assign bus.ovf        = ovf_q;
    assign bus.digit_code = code_q;
    assign bus.anode_n    = anode_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed and randomized checks of the display scan controller against a decimal reference model.
module tb_display_scan_controller;
    localparam int ND = 4;
    localparam int DW = 14;
    localparam int RD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    display_scan_controller_if #(.NUM_DIGITS(ND), .DATA_W(DW)) bus1 ();
    display_scan_controller_if #(.NUM_DIGITS(ND), .DATA_W(DW)) bus0 ();
    assign bus0.load  = bus1.load;
    assign bus0.value = bus1.value;

    display_scan_controller #(.NUM_DIGITS(ND), .DATA_W(DW), .REFRESH_DIV(RD), .LZ_BLANK(1))
        u_dut_lz (.clk(clk), .rst(rst), .bus(bus1));
    display_scan_controller #(.NUM_DIGITS(ND), .DATA_W(DW), .REFRESH_DIV(RD), .LZ_BLANK(0))
        u_dut_nolz (.clk(clk), .rst(rst), .bus(bus0));

    int checks   = 0;
    int failures = 0;

    logic [3:0] got1 [ND+1];
    logic [3:0] got0 [ND+1];
    int         cnt1 [ND+1];
    int         cnt0 [ND+1];
    int         prev1, prev0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decimal reference: digit i is (v / 10^i) % 10; too-large values show all blanks.
    function automatic logic model_ovf(input int v);
        return v > (10 ** ND) - 1;
    endfunction

    function automatic logic [ND*4-1:0] model_digits(input int v, input bit lz);
        logic [ND*4-1:0] r;
        int p;
        int d;
        p = 1;
        for (int i = 0; i < ND; i++) begin
            d = (v / p) % 10;
            if (model_ovf(v) || (lz && i > 0 && v < p)) r[i*4 +: 4] = 4'hF;
            else                                        r[i*4 +: 4] = d[3:0];
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int aidx(input logic [ND-1:0] a);
        for (int i = 0; i < ND; i++)
            if (a === ~(ND'(1) << i)) return i;
        return ND;
    endfunction

    task automatic clear_rec();
        for (int i = 0; i <= ND; i++) begin
            got1[i] = 'x; got0[i] = 'x; cnt1[i] = 0; cnt0[i] = 0;
        end
        prev1 = -1; prev0 = -1;
    endtask

    task automatic rec_cycle();
        int i1, i0;
        i1 = aidx(bus1.anode_n);
        i0 = aidx(bus0.anode_n);
        got1[i1] = bus1.digit_code; cnt1[i1]++;
        got0[i0] = bus0.digit_code; cnt0[i0]++;
        if (prev1 >= 0 && i1 != prev1) chk("scan_order_lz", i1, (prev1 + 1) % ND);
        if (prev0 >= 0 && i0 != prev0) chk("scan_order_nolz", i0, (prev0 + 1) % ND);
        prev1 = i1; prev0 = i0;
    endtask

    task automatic check_rec(input logic [ND*4-1:0] exp1, input logic [ND*4-1:0] exp0, input string tag);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("%s_lz_d%0d", tag, i), got1[i], exp1[i*4 +: 4]);
            chk($sformatf("%s_nolz_d%0d", tag, i), got0[i], exp0[i*4 +: 4]);
            chk($sformatf("%s_hold_d%0d", tag, i), cnt1[i], RD);
        end
        chk({tag, "_anode_onehot"}, cnt1[ND] + cnt0[ND], 0);
    endtask

    task automatic sample_display(input logic [ND*4-1:0] exp1, input logic [ND*4-1:0] exp0, input string tag);
        clear_rec();
        for (int c = 0; c < ND * RD; c++) begin
            @(negedge clk);
            rec_cycle();
        end
        check_rec(exp1, exp0, tag);
    endtask

    task automatic do_convert(input int v);
        string tag;
        tag = $sformatf("v%0d", v);
        $display("txn load value=%0d exp_ovf=%0b exp_digits=%h", v, model_ovf(v), model_digits(v, 1'b1));
        bus1.load  = 1'b1;
        bus1.value = DW'(v);
        for (int k = 1; k <= DW + 1; k++) begin
            @(negedge clk);
            bus1.load = 1'b0;
            chk({tag, "_busy"}, {bus1.busy, bus0.busy, bus1.done}, 3'b110);
        end
        @(negedge clk);
        chk({tag, "_done"}, {bus1.done, bus0.done, bus1.busy, bus0.busy}, 4'b1100);
        chk({tag, "_ovf"}, {bus1.ovf, bus0.ovf}, {2{model_ovf(v)}});
        sample_display(model_digits(v, 1'b1), model_digits(v, 1'b0), tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int done_cnt;
        logic [1:0] exp_pair;

        bus1.load  = 1'b0;
        bus1.value = '0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_flags", {bus1.busy, bus1.done, bus1.ovf, bus0.busy, bus0.done, bus0.ovf}, 6'b0);
        chk("rst_code", {bus1.digit_code, bus0.digit_code}, 8'hFF);
        chk("rst_anode", {bus1.anode_n, bus0.anode_n}, 8'b1110_1110);
        rst = 1'b0;
        $display("txn reset released");
        sample_display({ND{4'hF}}, {ND{4'hF}}, "post_rst");

        // Abort a conversion with reset part-way through.
        $display("txn load value=5678 with reset at T+8");
        bus1.load  = 1'b1;
        bus1.value = DW'(5678);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bus1.load = 1'b0;
            chk("abort_busy_pre", bus1.busy, 1'b1);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy_post", {bus1.busy, bus0.busy}, 2'b00);
        rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus1.done || bus0.done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        chk("abort_ovf", {bus1.ovf, bus0.ovf}, 2'b00);
        sample_display({ND{4'hF}}, {ND{4'hF}}, "abort");

        do_convert(1234);
        do_convert(7);
        do_convert(0);
        do_convert(12000);
        do_convert(9999);
        do_convert(10000);

        // Held load: one conversion of 42, then 55 accepted in its done cycle.
        $display("txn load held 20 cycles value=42 then 55");
        bus1.load  = 1'b1;
        bus1.value = DW'(42);
        clear_rec();
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (c == 1)  bus1.value = DW'(55);
            if (c == 20) bus1.load  = 1'b0;
            exp_pair = (c == 16 || c == 32) ? 2'b01 : 2'b10;
            chk($sformatf("held_c%0d", c), {bus1.busy, bus1.done}, exp_pair);
            if (c >= 17) rec_cycle();
        end
        check_rec(model_digits(42, 1'b1), model_digits(42, 1'b0), "held42");
        chk("held_ovf", {bus1.ovf, bus0.ovf}, 2'b00);
        sample_display(model_digits(55, 1'b1), model_digits(55, 1'b0), "held55");

        for (int r = 0; r < 12; r++) begin
            if (r % 3 == 0) v = int'($urandom_range(0, 99));
            else            v = int'($urandom_range(0, (1 << DW) - 1));
            do_convert(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
